// File: rtl/fsqrt_sched_pkg.sv
// rtl/fsqrt_sched_pkg.sv - shared types and helpers for the fsqrt scheduler
package fsqrt_sched_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32_t;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  // Negative inputs (including -0) and NaNs raise the flag; +inf does not.
  function automatic logic is_sqrt_exc(float32_t f);
    return f.sign | ((f.exp == EXP_MAX) && (f.man != 23'd0));
  endfunction

  // Tag width for n requesters, never narrower than one bit.
  function automatic int clog2(int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fsqrt_sched_if.sv
// rtl/fsqrt_sched_if.sv - requester-side issue and result bus of the fsqrt scheduler
interface fsqrt_sched_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    res_valid;
  logic [NREQ*32-1:0] res_y;
  logic [NREQ-1:0]    res_exc;
  logic [NREQ-1:0]    res_ready;

  modport master (
    output req_valid, req_x, res_ready,
    input  req_ready, res_valid, res_y, res_exc
  );

  modport slave (
    input  req_valid, req_x, res_ready,
    output req_ready, res_valid, res_y, res_exc
  );
endinterface

// File: rtl/fsqrt.sv
// rtl/fsqrt.sv - combinational float32 square root, truncating, subnormal-aware
module fsqrt
  import fsqrt_sched_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [24:0]       m2;
  logic signed [9:0] e2;
  logic [73:0]       rad;
  logic [36:0]       root;
  logic [39:0]       rem;
  logic [39:0]       trial;
  logic [5:0]        lead;
  logic [22:0]       norm;
  logic [7:0]        y_exp;

  // Make the radicand exponent even, take a 37-bit integer root, renormalise, then patch specials.
  always_comb begin
    m2 = (x[30:23] == 8'h00) ? {2'b00, x[22:0]} : {2'b01, x[22:0]};
    e2 = (x[30:23] == 8'h00) ? -10'sd149 : ($signed({2'b00, x[30:23]}) - 10'sd150);
    if (e2[0]) begin
      m2 = m2 << 1;
      e2 = e2 - 10'sd1;
    end
    rad   = {1'b0, m2, 48'd0};
    root  = '0;
    rem   = '0;
    trial = '0;
    for (int i = 36; i >= 0; i--) begin
      rem   = {rem[37:0], rad[2*i +: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[35:0], 1'b1};
      end else begin
        root = {root[35:0], 1'b0};
      end
    end
    // The 48-bit pre-shift guarantees the root's leading one sits at bit 24 or above.
    lead = 6'd24;
    for (int i = 24; i < 37; i++) begin
      if (root[i]) lead = 6'(i);
    end
    norm  = 23'(root >> (lead - 6'd23));
    y_exp = 8'(int'(lead) + int'(e2 >>> 1) + 103);

    if (x[30:0] == 31'd0)          y = x;
    else if (x[31])                y = 32'h7FC00000;
    else if (x[30:23] == EXP_MAX)  y = (x[22:0] == 23'd0) ? x : (x | 32'h00400000);
    else                           y = {1'b0, y_exp, norm};
  end

endmodule

// File: rtl/fsqrt_sched_rr_arbiter.sv
// rtl/fsqrt_sched_rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic found;

  // First requester at or after ptr wins, searching upward modulo N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + k) % N)) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fsqrt_sched.sv
// rtl/fsqrt_sched.sv - shares one fsqrt unit among NREQ requesters with per-requester result buffers
module fsqrt_sched
  import fsqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  fsqrt_sched_if.slave   bus,
  output logic           busy
);

  localparam int TW = clog2(NREQ);

  logic [TW-1:0]   ptr;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [TW-1:0]   gnt_idx;
  logic            accept;
  logic [NREQ-1:0] consume;
  logic [31:0]     x_sel;
  logic [31:0]     x_s1;
  logic [31:0]     y_s1;
  logic            exc_s1;
  logic [LAT-1:0]  v_pipe;
  logic [TW-1:0]   tag_pipe [LAT];
  logic [32:0]     wb_ye;

  assign elig    = bus.req_valid & ~pending;
  assign accept  = |gnt;
  assign consume = bus.res_valid & bus.res_ready;

  rr_arbiter #(.N(NREQ), .W(TW)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;

  // Route the granted requester's operand toward stage 1.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) x_sel = bus.req_x[32*i +: 32];
    end
  end

  // Rotate priority past each winner; pending blocks a requester until its result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      pending <= '0;
    end else begin
      if (accept) ptr <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      pending <= (pending | gnt) & ~consume;
    end
  end

  // Stage 1 captures the operand; valid and tag ride a LAT-deep shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= accept;
      for (int k = 1; k < LAT; k++) v_pipe[k] <= v_pipe[k-1];
    end
    x_s1        <= x_sel;
    tag_pipe[0] <= gnt_idx;
    for (int k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
  end

  fsqrt u_fsqrt (.x(x_s1), .y(y_s1));

  assign exc_s1 = is_sqrt_exc(float32_t'(x_s1));

  generate
    if (LAT > 1) begin : g_data
      logic [32:0] ye_q [LAT-1];
      // Result and flag follow stage 1 through the remaining LAT-1 stages.
      always_ff @(posedge clk) begin
        ye_q[0] <= {exc_s1, y_s1};
        for (int k = 1; k < LAT - 1; k++) ye_q[k] <= ye_q[k-1];
      end
      assign wb_ye = ye_q[LAT-2];
    end else begin : g_direct
      assign wb_ye = {exc_s1, y_s1};
    end
  endgenerate

  // Last stage fills the tagged buffer; consume empties it. Pending keeps the two off the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid <= '0;
      bus.res_y     <= '0;
      bus.res_exc   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (v_pipe[LAT-1] && (tag_pipe[LAT-1] == TW'(i))) begin
          bus.res_valid[i]        <= 1'b1;
          bus.res_y[32*i +: 32]   <= wb_ye[31:0];
          bus.res_exc[i]          <= wb_ye[32];
        end else if (consume[i]) begin
          bus.res_valid[i]        <= 1'b0;
        end
      end
    end
  end

  assign busy = (|v_pipe) | (|bus.res_valid);

endmodule
